dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory interface. It models a word-addressed data memory with a configurable access latency and a request/ready handshake.
- It sits between the RISC-V core's data port and the testbench/top level. It replaces the zero-latency combinational memory so that multi-cycle (stalling) cores and caches can be exercised.
- Data is stored and returned exactly as presented on the bus. Byte-lane swapping remains the core's responsibility.

Parameters:
- DEPTH, 256, number of 32-bit words in storage (power of two, >=4).
- ADDR_W, 32, width of mem_addr.
- LATENCY, 4, cycles from request acceptance to mem_ready (legal 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  input  1  read request; held by requester until mem_ready.
- mem_write  input  1  write request; held by requester until mem_ready.
- mem_addr  input  ADDR_W  byte address; word index = mem_addr[log2(DEPTH)+1:2].
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, valid when mem_ready=1 for a read.
- mem_ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n and has the following effect:
  - all storage words = 0;
  - state = IDLE, wait counter = 0;
  - mem_ready = 0, mem_rdata = 32'h0.
- Reset mid-operation aborts the access. A pending write is not committed.
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - At a rising edge with (mem_read | mem_write)=1, latch op, word index and wdata; counter = LATENCY-1.
  - Next state is WAIT, or RESP directly if LATENCY=1.
  - Latched values are used for the whole access. Bus changes after acceptance are ignored.
- WAIT: counter decrements each cycle. At the edge where counter==1, go to RESP.
- Commit happens on the edge entering RESP:
  - write: storage[index] <= latched wdata;
  - read: mem_rdata <= storage[index].
- RESP: mem_ready=1 for exactly this cycle; next state is IDLE unconditionally. Request inputs are ignored in RESP.
- Latency: request accepted at edge T gives mem_ready high during the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-to-back requests:
  - A request still asserted in the first IDLE cycle after RESP is treated as a new access.
  - The requester must deassert in the cycle following mem_ready unless it issues another request.
- mem_rdata holds its last read value through writes and idle cycles. It changes only on a read commit.
- mem_read & mem_write both 1: write takes priority; mem_rdata is unchanged.
- Address handling:
  - addr[1:0] is ignored (no misalignment trap).
  - Bits above the index wrap modulo DEPTH.
- Throughput: at most one access per LATENCY+1 cycles.

Optional Feature:
- Macro DMEM_ERR_EN.
- Defined:
  - adds output mem_err (1 bit, reset 0), valid only while mem_ready=1;
  - mem_err=1 if any latched address bit above the index field is set (out of range) or both read and write were requested;
  - an erroring write is dropped, storage is unchanged;
  - an erroring read returns 32'hDEADBEEF.
- Undefined: no mem_err port; wrap-around and write-priority rules above apply.

Test Plan:
1. Reset, then read addr 0x10 with LATENCY=4 -> mem_ready pulses exactly 4 cycles after acceptance, one cycle wide; mem_rdata=32'h0.
2. Write 0x12345678 to 0x20, then read 0x20 -> read returns 32'h12345678; mem_rdata unchanged during the write's RESP.
3. Change mem_addr/mem_wdata during WAIT of a write to 0x04 -> only the originally latched address/data are written; other words stay 0.
4. DEPTH=256, write 0xA5A5A5A5 to 0x400 -> wraps; read of 0x000 returns 32'hA5A5A5A5. With DMEM_ERR_EN: mem_err=1, write dropped, read 0x000 returns 0.
5. Hold mem_read high continuously with LATENCY=1 -> mem_ready pulses every 2nd cycle; each pulse returns the current storage value.
6. Assert rst_n=0 during WAIT of a write of 0xFFFFFFFF to 0x08, then release -> mem_ready stays 0; a later read of 0x08 returns 32'h0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory request/ready bus
//
// Bundles the data-memory handshake between a requester (the core) and the
// responder (the memory model).
//   mem_read  / mem_write : request, held by the requester until mem_ready
//   mem_addr  [ADDR_W]    : byte address
//   mem_wdata [32]        : write data
//   mem_rdata [32]        : read data, valid with mem_ready on a read
//   mem_ready             : one-cycle completion pulse
//   mem_err               : access error, only present with DMEM_ERR_EN
// Modports: master (requester side), slave (responder side).
// Optional feature macro: DMEM_ERR_EN.

interface dmem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
`ifdef DMEM_ERR_EN
  logic              mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );
`else
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with fixed access latency
//
// Responder end of the CPU data-memory bus. Accepts one read or write at a
// time, waits LATENCY cycles, then commits and pulses mem_ready for one cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (clears storage, aborts any access)
//   bus   : dmem_responder_if.slave (request/ready handshake)
// Parameters: DEPTH (words, power of two >= 4), ADDR_W, LATENCY (1..15).
// Optional feature macro: DMEM_ERR_EN (adds mem_err, out-of-range / read+write
// collisions are rejected instead of wrapping / prioritising the write).

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 4
) (
  input logic            clk,
  input logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [31:0]      mem [DEPTH];
  logic             lat_wr;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic [31:0]      rdata_q;
  logic             ready_q;

  logic             req;
  logic [IDX_W-1:0] bus_idx;
  logic             acc_wr;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic             commit;

  // Address bits outside the word index only matter for error detection.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[1:0], bus.mem_addr[ADDR_W-1:IDX_W+2]};

  assign req     = bus.mem_read | bus.mem_write;
  assign bus_idx = bus.mem_addr[IDX_W+1:2];

  // With LATENCY=1 the commit edge is the acceptance edge itself, so the
  // access fields come straight from the bus; otherwise from the latches.
  assign acc_wr    = (state == IDLE) ? bus.mem_write : lat_wr;
  assign acc_idx   = (state == IDLE) ? bus_idx       : lat_idx;
  assign acc_wdata = (state == IDLE) ? bus.mem_wdata : lat_wdata;

  assign commit = ((state == IDLE) && req && (LATENCY == 1)) ||
                  ((state == WAIT) && (cnt == 4'd1));

`ifdef DMEM_ERR_EN
  logic lat_err;
  logic bus_err;
  logic acc_err;
  logic err_q;

  assign bus_err = (|bus.mem_addr[ADDR_W-1:IDX_W+2]) | (bus.mem_read & bus.mem_write);
  assign acc_err = (state == IDLE) ? bus_err : lat_err;
  assign bus.mem_err = err_q;
`endif

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
`ifdef DMEM_ERR_EN
      lat_err   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            lat_wr    <= bus.mem_write;   // write wins when both are requested
            lat_idx   <= bus_idx;
            lat_wdata <= bus.mem_wdata;
            cnt       <= 4'(LATENCY - 1);
`ifdef DMEM_ERR_EN
            lat_err   <= bus_err;
`endif
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        ready_q <= 1'b1;
`ifdef DMEM_ERR_EN
        err_q <= acc_err;
        if (acc_err) begin
          if (!acc_wr) rdata_q <= 32'hDEADBEEF;
        end else if (acc_wr) begin
          mem[acc_idx] <= acc_wdata;
        end else begin
          rdata_q <= mem[acc_idx];
        end
`else
        if (acc_wr) mem[acc_idx] <= acc_wdata;
        else        rdata_q      <= mem[acc_idx];
`endif
      end
    end
  end

endmodule
